// File: rtl/drum_session_ctrl.sv
// Drum-kit session sequencer: count-in, pattern record into slot memory, and playback.
// Drives the memory port, the pad triggers and the state/seconds display fields.
module drum_session_ctrl #(
  parameter int unsigned PADS          = 8,
  parameter int unsigned SLOT_BITS     = 12,
  parameter int unsigned SONG_BITS     = 4,
  parameter int unsigned SONGS         = 12,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned COUNTIN_SEC   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           b_start,
  input  logic                           b_stop,
  input  logic                           record_mode,
  input  logic [SONG_BITS-1:0]           song_sel,
  input  logic [PADS-1:0]                hit,
  output logic [SONG_BITS+SLOT_BITS-1:0] mem_addr,
  output logic                           mem_we,
  output logic [PADS-1:0]                mem_wdata,
  input  logic [PADS-1:0]                mem_rdata,
  output logic [PADS-1:0]                trig,
  output logic [1:0]                     state,
  output logic [7:0]                     seconds
);

  localparam int unsigned TCW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned AW  = SONG_BITS + SLOT_BITS;
  localparam logic [SLOT_BITS-1:0] SLOT_MAX = '1;
  localparam logic [SLOT_BITS:0]   LEN_FULL = {1'b1, {SLOT_BITS{1'b0}}};
  localparam logic [TCW-1:0]       TC_LAST  = TCW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COUNTIN = 2'b01,
    S_RECORD  = 2'b10,
    S_PLAY    = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic                 start_prev_q, stop_prev_q;
  logic [SONG_BITS-1:0] cur_song_q, cur_song_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]           seconds_q, seconds_d;
  logic [PADS-1:0]      acc_q, acc_d;
  logic [SLOT_BITS:0]   len_q [SONGS];
  logic [SLOT_BITS:0]   len_d [SONGS];
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic [PADS-1:0]      wdata_q, wdata_d;
  logic [PADS-1:0]      trig_q, trig_d;
  logic                 fresh_q, fresh_d;
  logic                 pend_q, pend_d;

  logic                 start_edge, stop_edge, song_ok, play_tick;
  logic [SLOT_BITS-1:0] slot_inc;
  logic [SLOT_BITS:0]   slot_cnt;

  assign start_edge = b_start & ~start_prev_q;
  assign stop_edge  = b_stop & ~stop_prev_q;
  assign song_ok    = {1'b0, song_sel} < (SONG_BITS + 1)'(SONGS);
  assign slot_inc   = slot_q + 1'b1;
  assign slot_cnt   = {1'b0, slot_q} + (SLOT_BITS + 1)'(1);
  // Read data lags the address by a clock, so a tick landing on the first PLAY cycle is held over.
  assign play_tick  = (tick & ~fresh_q) | pend_q;

  always_comb begin
    state_d    = state_q;
    cur_song_d = cur_song_q;
    slot_d     = slot_q;
    tick_cnt_d = tick_cnt_q;
    seconds_d  = seconds_q;
    acc_d      = acc_q;
    len_d      = len_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    trig_d     = '0;
    fresh_d    = 1'b0;
    pend_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start_edge && !stop_edge && song_ok) begin
          cur_song_d = song_sel;
          tick_cnt_d = '0;
          if (record_mode) begin
            state_d   = S_COUNTIN;
            seconds_d = 8'(COUNTIN_SEC);
          end else if (len_q[song_sel] != '0) begin
            state_d   = S_PLAY;
            slot_d    = '0;
            seconds_d = '0;
            addr_d    = {song_sel, {SLOT_BITS{1'b0}}};
            fresh_d   = 1'b1;
          end
        end
      end

      S_COUNTIN: begin
        if (stop_edge) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (tick_cnt_q == TC_LAST) begin
            tick_cnt_d = '0;
            if (seconds_q <= 8'd1) begin
              state_d   = S_RECORD;
              slot_d    = '0;
              seconds_d = '0;
              acc_d     = '0;
              addr_d    = {cur_song_q, {SLOT_BITS{1'b0}}};
            end else begin
              seconds_d = seconds_q - 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_RECORD: begin
        acc_d  = acc_q | hit;
        trig_d = hit;
        addr_d = {cur_song_q, slot_q};
        if (tick) begin
          we_d    = 1'b1;
          wdata_d = acc_q | hit;
          acc_d   = '0;
          slot_d  = slot_inc;
          if (tick_cnt_q == TC_LAST) begin
            tick_cnt_d = '0;
            if (seconds_q != 8'hFF) seconds_d = seconds_q + 8'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (stop_edge) begin
            len_d[cur_song_q] = slot_cnt;
            state_d           = S_IDLE;
          end else if (slot_q == SLOT_MAX) begin
            len_d[cur_song_q] = LEN_FULL;
            state_d           = S_IDLE;
          end
        end else if (stop_edge) begin
          len_d[cur_song_q] = {1'b0, slot_q};
          acc_d             = '0;
          addr_d            = '0;
          state_d           = S_IDLE;
        end
      end

      S_PLAY: begin
        pend_d = tick & fresh_q;
        if (stop_edge) begin
          state_d = S_IDLE;
          addr_d  = '0;
          pend_d  = 1'b0;
        end else if (play_tick) begin
          trig_d = mem_rdata;
          slot_d = slot_inc;
          addr_d = {cur_song_q, slot_inc};
          if (tick_cnt_q == TC_LAST) begin
            tick_cnt_d = '0;
            if (seconds_q != 8'hFF) seconds_d = seconds_q + 8'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
          if (slot_cnt == len_q[cur_song_q]) begin
            state_d = S_IDLE;
            addr_d  = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= b_start;
      stop_prev_q  <= b_stop;
      cur_song_q   <= '0;
      slot_q       <= '0;
      tick_cnt_q   <= '0;
      seconds_q    <= '0;
      acc_q        <= '0;
      for (int unsigned i = 0; i < SONGS; i++) len_q[i] <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      trig_q       <= '0;
      fresh_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= b_start;
      stop_prev_q  <= b_stop;
      cur_song_q   <= cur_song_d;
      slot_q       <= slot_d;
      tick_cnt_q   <= tick_cnt_d;
      seconds_q    <= seconds_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      trig_q       <= trig_d;
      fresh_q      <= fresh_d;
      pend_q       <= pend_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign trig      = trig_q;
  assign state     = state_q;
  assign seconds   = seconds_q;

endmodule

// File: tb/tb_drum_session_ctrl.sv
// Scoreboard bench for drum_session_ctrl: expected writes/triggers are queued by the
// stimulus and consumed by a negedge monitor; state/seconds are checked at fixed points.
module tb_drum_session_ctrl;

  localparam int unsigned PADS = 8;
  localparam int unsigned SLB  = 3;
  localparam int unsigned SGB  = 4;
  localparam int unsigned AW   = SGB + SLB;

  logic            clk = 1'b0;
  logic            reset, tick, b_start, b_stop, record_mode;
  logic [SGB-1:0]  song_sel;
  logic [PADS-1:0] hit;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [PADS-1:0] mem_wdata, mem_rdata, trig;
  logic [1:0]      state;
  logic [7:0]      seconds;

  logic [PADS-1:0] mem [2**AW];

  logic [AW+PADS-1:0] wq [$];
  logic [PADS-1:0]    tq [$];
  int errors = 0;
  int checks = 0;

  drum_session_ctrl #(
    .PADS(PADS), .SLOT_BITS(SLB), .SONG_BITS(SGB), .SONGS(12),
    .TICKS_PER_SEC(4), .COUNTIN_SEC(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .b_start(b_start), .b_stop(b_stop),
    .record_mode(record_mode), .song_sel(song_sel), .hit(hit),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .trig(trig), .state(state), .seconds(seconds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, '0);
        else chk("write", {mem_addr, mem_wdata}, wq.pop_front());
      end
      if (trig != '0) begin
        if (tq.size() == 0) chk("unexpected_trig", trig, '0);
        else chk("trig", trig, tq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step();
    tick = 1'b0; step();
  endtask

  task automatic press_start();
    b_start = 1'b1; step();
    b_start = 1'b0; step();
  endtask

  task automatic press_stop();
    b_stop = 1'b1; step();
    b_stop = 1'b0; step();
  endtask

  task automatic start_record(input logic [SGB-1:0] s);
    song_sel = s; record_mode = 1'b1;
    press_start();
    repeat (12) do_tick();
  endtask

  // prior: hits already driven into this slot by the caller
  task automatic rec_slot(input logic [SGB-1:0] s, input logic [SLB-1:0] sl,
                          input logic [PADS-1:0] h1, input logic [PADS-1:0] ht,
                          input logic stp, input logic [PADS-1:0] prior);
    if (h1 != '0) begin
      hit = h1; tq.push_back(h1); step(); hit = '0;
    end
    tick = 1'b1; hit = ht; b_stop = stp;
    if (ht != '0) tq.push_back(ht);
    wq.push_back({s, sl, prior | h1 | ht});
    step();
    tick = 1'b0; hit = '0; b_stop = 1'b0;
    step();
  endtask

  task automatic play(input logic [SGB-1:0] s, input int n);
    song_sel = s; record_mode = 1'b0;
    press_start();
    chk("play_state", state, 2'b11);
    repeat (n - 1) do_tick();
    chk("play_not_done", state, 2'b11);
    do_tick();
    chk("play_done", state, 2'b00);
  endtask

  initial begin
    logic [PADS-1:0] w;
    reset = 1'b1; tick = 1'b0; b_start = 1'b1; b_stop = 1'b0;
    record_mode = 1'b0; song_sel = '0; hit = '0;

    // Reset with start held: no start fires
    repeat (3) step();
    reset = 1'b0;
    chk("rst_state", state, 2'b00);
    chk("rst_seconds", seconds, 8'd0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_trig", trig, '0);
    repeat (3) step();
    chk("held_start", state, 2'b00);
    b_start = 1'b0; step();

    // Start and stop together: stop wins
    song_sel = 4'd2; record_mode = 1'b1;
    b_start = 1'b1; b_stop = 1'b1; step();
    b_start = 1'b0; b_stop = 1'b0; step();
    chk("start_stop_same", state, 2'b00);

    // Count-in on song 2
    press_start();
    chk("countin_state", state, 2'b01);
    chk("countin_sec3", seconds, 8'd3);
    for (int s = 1; s <= 3; s++) begin
      repeat (4) do_tick();
      if (s < 3) chk("countin_sec", seconds, 8'(3 - s));
    end
    chk("record_state", state, 2'b10);
    chk("record_sec0", seconds, 8'd0);

    // Record 5 slots, then stop between ticks
    hit = 8'h01; tq.push_back(8'h01); step(); hit = '0;
    rec_slot(4'd2, 3'd0, 8'h80, 8'h00, 1'b0, 8'h01);
    rec_slot(4'd2, 3'd1, 8'h00, 8'h02, 1'b0, 8'h00);
    rec_slot(4'd2, 3'd2, 8'h04, 8'h00, 1'b0, 8'h00);
    rec_slot(4'd2, 3'd3, 8'h10, 8'h20, 1'b0, 8'h00);
    rec_slot(4'd2, 3'd4, 8'h40, 8'h00, 1'b0, 8'h00);
    chk("record_sec1", seconds, 8'd1);
    press_stop();
    chk("stop_idle", state, 2'b00);
    chk("stop_addr", mem_addr, '0);

    tq.push_back(8'h81); tq.push_back(8'h02); tq.push_back(8'h04);
    tq.push_back(8'h30); tq.push_back(8'h40);
    play(4'd2, 5);

    // Stop and tick together at slot 5 of song 3
    start_record(4'd3);
    for (int i = 0; i < 5; i++) rec_slot(4'd3, 3'(i), 8'(8'h10 + i), 8'h00, 1'b0, 8'h00);
    rec_slot(4'd3, 3'd5, 8'h00, 8'hA5, 1'b1, 8'h00);
    chk("stop_tick_idle", state, 2'b00);
    for (int i = 0; i < 5; i++) tq.push_back(8'(8'h10 + i));
    tq.push_back(8'hA5);
    play(4'd3, 6);

    // Empty song and out-of-range song
    song_sel = 4'd5; record_mode = 1'b0; press_start();
    chk("empty_song", state, 2'b00);
    chk("empty_addr", mem_addr, '0);
    song_sel = 4'd13; record_mode = 1'b1; press_start();
    chk("bad_song", state, 2'b00);

    // Full-length record on song 7 ends by itself
    start_record(4'd7);
    for (int i = 0; i < 7; i++) rec_slot(4'd7, 3'(i), 8'(8'h01 << i), 8'h00, 1'b0, 8'h00);
    chk("full_not_done", state, 2'b10);
    rec_slot(4'd7, 3'd7, 8'h00, 8'h80, 1'b0, 8'h00);
    chk("full_done", state, 2'b00);
    chk("full_seconds", seconds, 8'd2);
    for (int i = 0; i < 8; i++) begin
      w = 8'(8'h01 << i);
      tq.push_back(w);
    end
    play(4'd7, 8);
    repeat (2) do_tick();
    chk("idle_after_play", state, 2'b00);

    repeat (4) step();
    chk("wq_drained", wq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
